// File: rtl/count_reader_if.sv
// ---------------------------------------------------------------------------
// count_reader_if
// Output beat stream of the counter read-out engine toward the host DMA path.
//
// Signals:
//   o_valid  beat valid (driven by master)
//   o_count  counter value of the beat (WIDTH bits)
//   o_index  table index of the beat (ABIT bits)
//   o_last   beat carries the final index of the table
//   i_ready  downstream accepts the beat when o_valid & i_ready (driven by slave)
//
// Modports:
//   master   the read-out engine
//   slave    the downstream consumer
// ---------------------------------------------------------------------------
interface count_reader_if #(
    parameter int WIDTH = 32,
    parameter int ABIT  = 9
);
    logic             o_valid;
    logic [WIDTH-1:0] o_count;
    logic [ABIT-1:0]  o_index;
    logic             o_last;
    logic             i_ready;

    modport master (
        output o_valid,
        output o_count,
        output o_index,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_valid,
        input  o_count,
        input  o_index,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/count_reader.sv
// ---------------------------------------------------------------------------
// count_reader
// Scans a per-index counter table through its free read port on a start
// pulse, streams every (index, count) pair in increasing index order, and
// optionally zeroes each entry right after it has been read.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   i_start      one-cycle start pulse, honoured only while idle
//   i_clear      sampled with i_start; 1 = read-and-clear
//   o_busy       scan in progress
//   o_done       one-cycle pulse after the last beat has been accepted
//   o_rd_en      table read enable (data returns two cycles later)
//   o_rd_adr     table read address
//   i_rd_data    table read data
//   o_clr_we     table write enable used for clearing
//   o_clr_adr    table write address used for clearing
//   o_clr_din    table write data, always zero
//   m_out        output beat stream (valid/ready)
// ---------------------------------------------------------------------------
module count_reader #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32,
    localparam int ABIT = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_clear,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_en,
    output logic [ABIT-1:0]  o_rd_adr,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic             o_clr_we,
    output logic [ABIT-1:0]  o_clr_adr,
    output logic [WIDTH-1:0] o_clr_din,
    count_reader_if.master   m_out
);

    localparam int FIFO_DEPTH = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ABIT-1:0] LAST_IDX = ABIT'(DEPTH - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_d;
    logic            r_clr;
    logic [ABIT-1:0] r_adr;

    // Read pipeline: stage 1 = RAM address registered, stage 2 = data present.
    logic            r_p1_v;
    logic [ABIT-1:0] r_p1_idx;
    logic            r_p2_v;
    logic [ABIT-1:0] r_p2_idx;

    // Output skid FIFO; its head is the registered output beat.
    logic [WIDTH-1:0] r_fifo_cnt [FIFO_DEPTH];
    logic [ABIT-1:0]  r_fifo_idx [FIFO_DEPTH];
    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;
    logic [2:0]       r_occ;

    logic       w_rd;
    logic       w_push;
    logic       w_pop;
    logic [2:0] w_occ_d;
    logic [2:0] w_credits;
    logic       w_valid;

    assign w_valid = (r_occ != 3'd0);
    assign w_push  = r_p2_v;
    assign w_pop   = w_valid && m_out.i_ready;
    assign w_occ_d = r_occ + {2'b00, w_push} - {2'b00, w_pop};

    // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign w_credits = r_occ + {2'b00, r_p1_v} + {2'b00, r_p2_v};
    assign w_rd      = (r_state == S_SCAN) && (w_credits < 3'(FIFO_DEPTH));

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_d = S_SCAN;
            S_SCAN:  if (w_rd && (r_adr == LAST_IDX)) w_state_d = S_DRAIN;
            S_DRAIN: if (!r_p1_v && !r_p2_v && (w_occ_d == 3'd0)) w_state_d = S_DONE;
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_clr    <= 1'b0;
            r_adr    <= '0;
            r_p1_v   <= 1'b0;
            r_p1_idx <= '0;
            r_p2_v   <= 1'b0;
            r_p2_idx <= '0;
        end else begin
            r_state  <= w_state_d;
            r_p1_v   <= w_rd;
            r_p1_idx <= r_adr;
            r_p2_v   <= r_p1_v;
            r_p2_idx <= r_p1_idx;
            if (r_state == S_IDLE && i_start) begin
                r_clr <= i_clear;
                r_adr <= '0;
            end else if (w_rd && (r_adr != LAST_IDX)) begin
                // Address holds at the final index; no second pass.
                r_adr <= r_adr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_cnt[i] <= '0;
                r_fifo_idx[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_cnt[r_wptr] <= i_rd_data;
                r_fifo_idx[r_wptr] <= r_p2_idx;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_occ <= w_occ_d;
        end
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = (r_state == S_DONE);
    assign o_rd_en  = w_rd;
    assign o_rd_adr = r_adr;

    // Clearing trails the read by two cycles, so it never hits the address being read.
    assign o_clr_we  = r_clr && r_p2_v;
    assign o_clr_adr = r_p2_idx;
    assign o_clr_din = '0;

    assign m_out.o_valid = w_valid;
    assign m_out.o_count = r_fifo_cnt[r_rptr];
    assign m_out.o_index = r_fifo_idx[r_rptr];
    assign m_out.o_last  = w_valid && (r_fifo_idx[r_rptr] == LAST_IDX);

endmodule

// File: doc/count_reader.md
Name: count_reader

Overview:
Read-out engine for the per-index counter table maintained by the counter update pipeline. On a start pulse it scans every index 0..DEPTH-1 through the table's free read port. It emits each (index, count) pair on a valid/ready stream toward the host DMA path. Optionally it zeroes each entry after reading it (read-and-clear).

Parameters:
DEPTH, 512, number of counter entries; power of two, >= 4
WIDTH, 32, counter width in bits
ABIT, f_enc_bits(DEPTH), index width (localparam)
FIFO_DEPTH, 4, output skid FIFO entries; fixed at 4

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_start  in  1  one-cycle pulse; begin scan (ignored unless idle)
i_clear  in  1  sampled with i_start; 1 = zero each entry after reading it
o_busy  out  1  high from the cycle after accepted start until the cycle o_done pulses
o_done  out  1  one-cycle pulse after the last beat is accepted
o_rd_en  out  1  RAM read enable
o_rd_adr  out  ABIT  RAM read address
i_rd_data  in  WIDTH  RAM read data; valid exactly 2 cycles after o_rd_en (PIPE=1 RAM)
o_clr_we  out  1  RAM write enable for clearing
o_clr_adr  out  ABIT  RAM write address for clearing
o_clr_din  out  WIDTH  constant zero
o_valid  out  1  output beat valid
o_count  out  WIDTH  count value
o_index  out  ABIT  index of the count
o_last  out  1  beat carries index DEPTH-1
i_ready  in  1  downstream accepts the beat when o_valid & i_ready

Behaviour:
- Reset (async): state IDLE; every output 0; FIFO emptied; address counter, in-flight shift register and credit count cleared. Reset mid-scan abandons the scan. No o_done pulse. A partially cleared table stays partially cleared.
- States:
  - IDLE: i_start -> SCAN; latch the clear flag; rd address counter = 0.
  - SCAN: one read per cycle while credits < FIFO_DEPTH. Credits = reads in flight (0..2) + FIFO occupancy. Issuing a read at address DEPTH-1 -> DRAIN.
  - DRAIN: no reads. Wait until in-flight = 0, FIFO empty and the last beat is accepted -> DONE.
  - DONE: o_done = 1 for one cycle -> IDLE.
- Start handling: i_start in any state other than IDLE is ignored. A start accepted at cycle 0 sets o_busy at cycle 1 and issues the first o_rd_en at cycle 1.
- Read pipeline: a 2-stage shift register carries (valid, index) alongside each read. At cycle t+2 i_rd_data and its index are pushed into the FIFO. The FIFO output is registered, so o_valid first rises at t+3.
  - From i_start at cycle 0, first o_valid is at cycle 4 with o_index = 0.
- Throughput: with i_ready held high, one beat per cycle. Total from start to o_done = DEPTH + 4 cycles.
- Backpressure: o_valid, o_count, o_index and o_last hold steady while o_valid & !i_ready. The credit rule guarantees the FIFO never overflows, so no beat is dropped or duplicated.
- Clear: if clear is latched, o_clr_we pulses in the same cycle the read data is pushed (t+2), with o_clr_adr = that index. Each index is cleared exactly once. The zero-write never coincides with the read of the same index.
- Ordering: beats are emitted in strictly increasing index order, 0..DEPTH-1.
  - o_last = 1 only on index DEPTH-1.
  - The index counter stops at DEPTH-1 and does not wrap into a second pass.
- Concurrent updates: the owner must gate the update pipeline while o_busy is high. No hazard detection is done here.
- Simultaneous events:
  - i_start in the same cycle as o_done: ignored (state is not IDLE).
  - Push and pop in the same cycle: occupancy unchanged.

Test Plan:
- DEPTH=16, table preloaded with count[i]=i*3, i_clear=0, i_ready=1 -> 16 beats at cycles 4..19 with index 0..15, count 0..45, o_last only on index 15; o_done at cycle 20; table unchanged.
- Same preload, i_ready toggling 1,0,0,1,… random -> identical 16-beat sequence, no drops or duplicates; o_valid and data stable during stalls; rd_en never issued with credits = 4.
- i_clear=1, preload count[i]=i+1 -> emitted counts 1..16; 16 o_clr_we pulses, one per index; a second scan returns all zeros.
- i_start pulsed again at cycle 8 mid-scan -> ignored; exactly one o_done; exactly 16 beats.
- rst asserted asynchronously at cycle 10 mid-scan -> all outputs 0 immediately; no o_done. A new i_start after release gives a full clean 0..15 scan.
- i_ready held 0 for 50 cycles after start -> FIFO fills to 4, o_rd_en stops. On release, beats resume at index 0 with no gaps.
